// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
`timescale 1ns/1ps

interface if_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues in-order imem requests and buffers returned instructions for decode.
// Optional macro IF_PERF_CNT_EN adds saturating fetch/drop performance counters.
`timescale 1ns/1ps

module if_fetch_stage #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          FB_DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  if_fetch_stage_if.master        imem,
  output logic                    id_valid,
  output logic [63:0]             id_pc,
  output logic [31:0]             id_inst,
  input  logic                    id_stall,
  input  logic                    redirect_valid,
  input  logic [63:0]             redirect_pc
`ifdef IF_PERF_CNT_EN
  ,
  output logic [63:0]             perf_fetch_cnt,
  output logic [63:0]             perf_drop_cnt
`endif
);

  localparam int            PW      = (FB_DEPTH > 1) ? $clog2(FB_DEPTH) : 1;
  localparam int            CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FB_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  logic [63:0]   pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] buf_count;
  logic [PW-1:0] tag_wr_ptr;
  logic [PW-1:0] tag_rd_ptr;
  logic [PW-1:0] buf_wr_ptr;
  logic [PW-1:0] buf_rd_ptr;
  logic [63:0]   tag_mem  [FB_DEPTH];
  logic [63:0]   buf_pc   [FB_DEPTH];
  logic [31:0]   buf_inst [FB_DEPTH];

  logic          req_fire;
  logic          rsp_take;
  logic          buf_push;
  logic          buf_pop;
  logic [CW:0]   occupancy;
  logic          unused_redirect_lsbs;

  // Credit: in-flight plus buffered never exceeds the buffer size, so pushes cannot overflow.
  assign occupancy            = {1'b0, inflight} + {1'b0, buf_count};
  assign imem.imem_req_valid  = !rst && !redirect_valid && (occupancy < {1'b0, DEPTH_C});
  assign imem.imem_req_addr   = pc;
  assign req_fire             = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_take             = imem.imem_rsp_valid && (inflight != '0);
  assign buf_push             = rsp_take && (drop_cnt == '0) && !redirect_valid;
  assign id_valid             = (buf_count != '0);
  assign buf_pop              = id_valid && !id_stall && !redirect_valid;
  assign id_pc                = id_valid ? buf_pc[buf_rd_ptr] : '0;
  assign id_inst              = id_valid ? buf_inst[buf_rd_ptr] : NOP;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= {RESET_PC[63:2], 2'b00};
      inflight   <= '0;
      drop_cnt   <= '0;
      tag_wr_ptr <= '0;
      tag_rd_ptr <= '0;
    end else begin
      if (redirect_valid) begin
        pc <= {redirect_pc[63:2], 2'b00};
      end else if (req_fire) begin
        pc <= pc + 64'd4;
      end
      inflight <= inflight + CW'(req_fire) - CW'(rsp_take);
      // Everything still outstanding after this cycle belongs to the wrong path.
      if (redirect_valid) begin
        drop_cnt <= inflight - CW'(rsp_take);
      end else if (rsp_take && (drop_cnt != '0)) begin
        drop_cnt <= drop_cnt - 1'b1;
      end
      if (req_fire) begin
        tag_wr_ptr <= tag_wr_ptr + 1'b1;
      end
      if (rsp_take) begin
        tag_rd_ptr <= tag_rd_ptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      buf_count  <= '0;
    end else if (redirect_valid) begin
      buf_wr_ptr <= '0;
      buf_rd_ptr <= '0;
      buf_count  <= '0;
    end else begin
      if (buf_push) begin
        buf_wr_ptr <= buf_wr_ptr + 1'b1;
      end
      if (buf_pop) begin
        buf_rd_ptr <= buf_rd_ptr + 1'b1;
      end
      buf_count <= buf_count + CW'(buf_push) - CW'(buf_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      tag_mem[tag_wr_ptr] <= pc;
    end
    if (buf_push) begin
      buf_pc[buf_wr_ptr]   <= tag_mem[tag_rd_ptr];
      buf_inst[buf_wr_ptr] <= imem.imem_rsp_data;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        rsp_drop;
  logic [CW:0] drop_inc;

  // A response arriving in a redirect cycle is discarded too, alongside every flushed buffer entry.
  assign rsp_drop = rsp_take && ((drop_cnt != '0) || redirect_valid);
  assign drop_inc = (CW+1)'(rsp_drop) + (redirect_valid ? {1'b0, buf_count} : '0);

  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [CW:0] b);
    logic [64:0] s;
    s = {1'b0, a} + 65'(b);
    return s[64] ? '1 : s[63:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_fetch_cnt <= sat_add(perf_fetch_cnt, (CW+1)'(req_fire));
      perf_drop_cnt  <= sat_add(perf_drop_cnt, drop_inc);
    end
  end
`endif

endmodule
